aes_inv_cipher_iter: RTL and testbench
======================================

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  ciphertext block offered.
REQ-005 in_ready  output  1  block can accept a ciphertext this cycle.
REQ-006 ciphertext  input  128  block to decrypt; byte k (0..15) at bits [127-8k:120-8k], byte k = state row k%4, column k/4.
REQ-007 rk_idx  output  4  round-key index requested from the key store (10..0).
REQ-008 round_key  input  128  round key for rk_idx, combinational from key store, sampled the same cycle; same byte order as ciphertext.
REQ-009 out_valid  output  1  plaintext valid.
REQ-010 out_ready  input  1  consumer accepts plaintext.
REQ-011 plaintext  output  128  decrypted block, same byte order.
REQ-012 busy  output  1  high in RUN or DONE.
REQ-013 The block SHALL instantiate 16 copies of the team inverse S-box (inv_sbox, 8-bit in, 8-bit out, combinational).

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; 4-bit round counter rnd.
REQ-015 IDLE: in_ready=1, out_valid=0, rk_idx=10.
REQ-016 Accept on in_valid&&in_ready: state <= ciphertext ^ round_key (rk 10), rnd <= 9, go RUN.
REQ-017 RUN: in_ready=0, rk_idx=rnd; each cycle state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key), rnd decrements, while rnd>=1.
REQ-018 RUN with rnd=0: state <= InvSubBytes(InvShiftRows(state)) ^ round_key (no InvMixColumns), go DONE.
REQ-019 InvShiftRows: out byte (r,c) = in byte (r,(c-r) mod 4); e.g. out[119:112]=in[23:16], out[111:104]=in[47:40], out[103:96]=in[71:64].
REQ-020 InvMixColumns per column SHALL multiply by matrix rows {0e,0b,0d,09} rotated, GF(2^8) mod x^8+x^4+x^3+x+1.
REQ-021 Latency: out_valid SHALL rise exactly 11 clk edges after the accept edge (1 initial AddRoundKey + 10 rounds).
REQ-022 DONE: out_valid=1, plaintext=state, held stable until out_ready sampled high; in_ready=0.
REQ-023 On out_valid&&out_ready: go IDLE; in_ready high next cycle (no same-cycle accept; throughput 1 block / 12 cycles minimum).
REQ-024 in_valid during RUN/DONE SHALL be ignored; ciphertext changes after accept SHALL not affect result.
REQ-025 out_ready while not out_valid SHALL be ignored.
REQ-026 plaintext SHALL equal state register in all states (only qualified by out_valid).

Reset
REQ-027 rst high SHALL immediately force IDLE, rnd=0, state=0, out_valid=0, in_ready=1 after release, busy=0, rk_idx=10, plaintext=0.
REQ-028 rst asserted mid-RUN or in DONE SHALL discard the block; no out_valid until a new accept.
REQ-029 First accept SHALL be possible on the first rising edge with rst low.

Verification
REQ-030 FIPS-197 C.1: key 000102..0f (bench key-schedule model drives round_key per rk_idx), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid 11 edges after accept.
REQ-031 rk_idx trace: sample each cycle from accept -> 10,9,8,...,1,0 then 10 in IDLE.
REQ-032 Backpressure: out_ready low 5 cycles after out_valid -> plaintext and out_valid stable, in_ready 0, then handshake -> IDLE.
REQ-033 Reset mid-op: rst pulse at round 5 -> out_valid stays 0, in_ready 1 after release; next C.1 block decrypts correctly.
REQ-034 Back-to-back: in_valid held high with two blocks, out_ready tied 1 -> two correct plaintexts, accepts 12 cycles apart.
REQ-035 Ignore: toggle in_valid/ciphertext during RUN -> result unchanged from C.1 plaintext.

Source files
------------

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and data bundle between the AES-128 inverse cipher and its environment.
// Latency: none; wires only.
// Backpressure: in_valid/in_ready on the ciphertext side, out_valid/out_ready on the plaintext side.
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  // Environment side: offers ciphertext, serves round keys, consumes plaintext.
  modport master (
    output in_valid, ciphertext, round_key, out_ready,
    input  in_ready, rk_idx, out_valid, plaintext, busy
  );

  // Cipher side.
  modport slave (
    input  in_valid, ciphertext, round_key, out_ready,
    output in_ready, rk_idx, out_valid, plaintext, busy
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched from an external store.
// Latency: out_valid on the 11th rising edge counting the accept edge; one block every 12 cycles at best.
// Backpressure: plaintext held in DONE until out_ready; in_ready low from accept until the handshake.

// Inverse S-box: inverse affine transform followed by GF(2^8) multiplicative inverse.
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_pre;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 by square-and-multiply over exponent 1111_1110b; maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  // Inverse affine: b_i = s_(i+2) ^ s_(i+5) ^ s_(i+7) ^ 0x05.
  assign w_pre  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                  {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
  assign o_byte = gf_inv(w_pre);
endmodule

module aes_inv_cipher_iter (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_cipher_iter_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_state;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [3:0]   r_rk_idx;

  logic [127:0] w_isr;   // after InvShiftRows
  logic [127:0] w_isb;   // after InvSubBytes
  logic [127:0] w_ark;   // after AddRoundKey
  logic [127:0] w_imc;   // after InvMixColumns

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Byte k sits at row k%4, column k/4; row r is rotated right by r columns.
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int ROW = k % 4;
    localparam int COL = k / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign w_isr[127-8*k -: 8] = r_state[127-8*SRC -: 8];
    inv_sbox u_inv_sbox (
      .i_byte (w_isr[127-8*k -: 8]),
      .o_byte (w_isb[127-8*k -: 8])
    );
  end

  assign w_ark = w_isb ^ io_bus.round_key;

  // Each column multiplied by the circulant {0e,0b,0d,09}.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[127-32*c -: 8];
    assign w_a1 = w_ark[119-32*c -: 8];
    assign w_a2 = w_ark[111-32*c -: 8];
    assign w_a3 = w_ark[103-32*c -: 8];
    assign w_imc[127-32*c -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^ gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
    assign w_imc[119-32*c -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^ gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
    assign w_imc[111-32*c -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^ gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
    assign w_imc[103-32*c -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
  end

  // Control FSM and state register; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_rnd       <= 4'd0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rk_idx    <= 4'd10;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (io_bus.in_valid) begin
            // Initial AddRoundKey with round key 10 (rk_idx is 10 in IDLE).
            r_state    <= io_bus.ciphertext ^ io_bus.round_key;
            r_rnd      <= 4'd9;
            r_rk_idx   <= 4'd9;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= RUN;
          end
        end
        RUN: begin
          if (r_rnd == 4'd0) begin
            // Final round omits InvMixColumns.
            r_state     <= w_ark;
            r_rk_idx    <= 4'd10;
            r_out_valid <= 1'b1;
            r_fsm       <= DONE;
          end else begin
            r_state  <= w_imc;
            r_rnd    <= r_rnd - 4'd1;
            r_rk_idx <= r_rnd - 4'd1;
          end
        end
        DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm       <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.busy      = r_busy;
  assign io_bus.rk_idx    = r_rk_idx;
  assign io_bus.plaintext = r_state;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for the iterative AES-128 inverse cipher: FIPS-197 C.1 vector plus random keys/blocks
// checked against a byte-array reference decryptor, round keys served from a key-schedule model.
module tb_aes_inv_cipher_iter;
  logic clk;
  logic rst;
  aes_inv_cipher_iter_if bus ();

  aes_inv_cipher_iter dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rks     [11];

  // Key store: combinational lookup by the requested round-key index.
  assign bus.round_key = (bus.rk_idx <= 4'd10) ? rks[bus.rk_idx] : '0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Forward S-box by brute-force inverse and affine map; inverse table by reversal.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher on a 16-byte array.
  function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [7:0] coef [4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rks[10][127-8*k -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
      for (int k = 0; k < 16; k++) s[k] = isbox_t[t[k]] ^ rks[rd][127-8*k -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c + j];
          for (int r = 0; r < 4; r++) begin
            s[4*c + r] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c + r] ^= gmul(a[j], coef[(j - r + 4) % 4]);
          end
        end
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // Called at a falling edge while idle; returns at a falling edge, idle again.
  task automatic do_block(input logic [127:0] ct, input logic [127:0] exp, input int hold, input bit noise);
    int e;
    chk("idle_in_ready", 128'(bus.in_ready), 128'(1));
    chk("idle_rk_idx", 128'(bus.rk_idx), 128'(10));
    bus.in_valid   = 1'b1;
    bus.ciphertext = ct;
    bus.out_ready  = 1'b0;
    e = 0;
    forever begin
      @(posedge clk); e++;
      @(negedge clk);
      if (bus.out_valid || e >= 20) break;
      chk("run_rk_idx", 128'(bus.rk_idx), 128'(10 - e));
      chk("run_in_ready", 128'(bus.in_ready), 128'(0));
      chk("run_busy", 128'(bus.busy), 128'(1));
      bus.in_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ciphertext = rand128();
      bus.out_ready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    // Edge count includes the accept edge itself.
    chk("latency", 128'(e), 128'(11));
    chk("plaintext", bus.plaintext, exp);
    chk("done_in_ready", 128'(bus.in_ready), 128'(0));
    chk("done_busy", 128'(bus.busy), 128'(1));
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_plaintext", bus.plaintext, exp);
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid", 128'(bus.out_valid), 128'(0));
    chk("post_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_busy", 128'(bus.busy), 128'(0));
    chk("post_rk_idx", 128'(bus.rk_idx), 128'(10));
    chk("post_plaintext", bus.plaintext, exp);
  endtask

  initial begin
    logic [127:0] ct2;
    logic [127:0] exp2;
    logic [127:0] outs [$];
    int acc [$];
    int cyc;
    logic [127:0] key;
    logic [127:0] ct;

    build_tables();
    set_key(C1_KEY);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ciphertext = '0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
    chk("rst_plaintext", bus.plaintext, 128'h0);
    rst = 1'b0;

    // C.1 vector, accepted on the first edge after reset release, with rk_idx trace.
    do_block(C1_CT, C1_PT, 0, 1'b0);
    // Backpressure for 5 cycles.
    do_block(C1_CT, C1_PT, 5, 1'b0);
    // Input noise during RUN/DONE must be ignored.
    do_block(C1_CT, C1_PT, 2, 1'b1);

    // Reset at round 5 discards the block.
    bus.in_valid = 1'b1;
    bus.ciphertext = C1_CT;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    chk("midrst_rk_idx", 128'(bus.rk_idx), 128'(10));
    chk("midrst_plaintext", bus.plaintext, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      chk("midrst_quiet_out_valid", 128'(bus.out_valid), 128'(0));
      chk("midrst_quiet_in_ready", 128'(bus.in_ready), 128'(1));
    end
    do_block(C1_CT, C1_PT, 0, 1'b0);

    // Back-to-back: in_valid held high, out_ready tied high.
    ct2 = rand128();
    exp2 = model_decrypt(ct2);
    bus.in_valid = 1'b1;
    bus.ciphertext = C1_CT;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (cyc < 60 && outs.size() < 2) begin
      if (bus.in_valid && bus.in_ready) acc.push_back(cyc);
      if (bus.out_valid && bus.out_ready) outs.push_back(bus.plaintext);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (acc.size() == 1) bus.ciphertext = ct2;
      if (acc.size() >= 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_out_count", 128'(outs.size()), 128'(2));
    chk("b2b_acc_count", 128'(acc.size()), 128'(2));
    if (outs.size() >= 2) begin
      chk("b2b_pt0", outs[0], C1_PT);
      chk("b2b_pt1", outs[1], exp2);
    end
    if (acc.size() >= 2) chk("b2b_accept_gap", 128'(acc[1] - acc[0]), 128'(12));
    @(negedge clk);

    // Random keys and blocks against the reference decryptor.
    for (int i = 0; i < 6; i++) begin
      key = rand128();
      set_key(key);
      ct = rand128();
      do_block(ct, model_decrypt(ct), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
